// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the memory-stage load/store unit.
//   - func3 load/store size/sign codes
//   - writeback source select codes
//   - LSU bus FSM state encoding
//   - misalign helper shared by the stage control logic
package lsu_pkg;

    // Load func3 codes
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store func3 codes
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Writeback source select
    localparam logic [1:0] SEL_ALU   = 2'd0;
    localparam logic [1:0] SEL_LOAD  = 2'd1;
    localparam logic [1:0] SEL_PCIMM = 2'd2;
    localparam logic [1:0] SEL_IMM   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_e;

    // Size is carried in func3[1:0] for both loads and stores; bit 2 only
    // selects zero-extension on loads and never affects alignment.
    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic       is_st,
                                        input logic [1:0] off);
        logic [1:0] byte_c;
        logic [1:0] half_c;
        logic [1:0] word_c;
        byte_c = is_st ? SB[1:0] : LB[1:0];
        half_c = is_st ? SH[1:0] : LH[1:0];
        word_c = is_st ? SW[1:0] : LW[1:0];
        if (f3[1:0] == byte_c)      return 1'b0;
        else if (f3[1:0] == half_c) return off[0];
        else if (f3[1:0] == word_c) return (off != 2'b00);
        else                        return 1'b0;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: extracts the addressed byte/halfword/word from a 32-bit bus
// read word and sign- or zero-extends it.
//   rdata_i  : raw word returned by data memory
//   offset_i : byte lane (address bits [1:0])
//   func3_i  : load size/sign code
//   data_o   : aligned, extended load value
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  func3_i,
    output logic [31:0] data_o
);

    // Move the addressed lane down to bit 0 once; every size then reads
    // from the low bits.
    logic [31:0] shifted;
    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = rdata_i;
        case (func3_i)
            LB:      data_o = {{24{shifted[7]}},  shifted[7:0]};
            LH:      data_o = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     data_o = {24'd0, shifted[7:0]};
            LHU:     data_o = {16'd0, shifted[15:0]};
            LW:      data_o = rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage of the 5-stage RV32 pipeline.
//   Issues loads/stores on a req/gnt/rvalid data bus, aligns load data,
//   stalls upstream while an access is in flight and registers the
//   writeback value into the MEM/WB outputs.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   mem_*_in              : EX/MEM pipeline register contents
//   dmem_req/we/addr/be/wdata, dmem_gnt/rvalid/rdata : data bus
//   lsu_stall             : combinational freeze of IF/ID/EX and EX/MEM
//   wb_result/wb_rd/wb_reg_wr : registered MEM/WB outputs
//   misalign_err, err_addr    : one-cycle error pulse and faulting address
// Build option:
//   MEM_TIMEOUT_EN : abandon a bus access after TIMEOUT_CYCLES cycles in
//                    REQ/WAIT and report it through misalign_err.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int XLEN           = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] mem_alu_out_in,
    input  logic [XLEN-1:0] mem_rv1_in,
    input  logic [XLEN-1:0] mem_pc_imm_in,
    input  logic [XLEN-1:0] mem_imm_in,
    input  logic [4:0]      mem_rd_in,
    input  logic [1:0]      mem_reg_in_sel_in,
    input  logic [3:0]      mem_dwe_in,
    input  logic [2:0]      mem_func3_in,
    input  logic            mem_mem_reg_in,
    input  logic            mem_reg_wr_in,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            lsu_stall,
    output logic [XLEN-1:0] wb_result,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_wr,
    output logic            misalign_err,
    output logic [XLEN-1:0] err_addr
);

    lsu_state_e state_q, state_d;

    logic [XLEN-1:0] wb_result_q;
    logic [4:0]      wb_rd_q;
    logic            wb_reg_wr_q;
    logic            misalign_err_q;
    logic [XLEN-1:0] err_addr_q;

    logic            op_ld, op_st, op_any;
    logic [1:0]      offset;
    logic            mis_c;
    logic            req_c;
    logic            stall_c;
    logic            tmo_c;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] wb_sel;

    // A load with stray store enables is treated as a plain load.
    assign op_ld  = mem_mem_reg_in;
    assign op_st  = (|mem_dwe_in) && !op_ld;
    assign op_any = op_ld || op_st;
    assign offset = mem_alu_out_in[1:0];

    // Misalignment is only meaningful when a new access is being
    // considered; once in REQ/WAIT the access has already been accepted.
    assign mis_c = (state_q == IDLE) && op_any &&
                   misaligned(mem_func3_in, op_st, offset);

    // Bus address/data/enables come straight from EX/MEM: the stall keeps
    // that register frozen, so they stay stable for the whole REQ phase.
    assign dmem_addr  = {mem_alu_out_in[XLEN-1:2], 2'b00};
    assign dmem_be    = mem_dwe_in << offset;
    assign dmem_wdata = mem_rv1_in << {offset, 3'b000};
    assign dmem_req   = req_c && !reset;
    assign dmem_we    = req_c && !reset && op_st;

    assign lsu_stall  = stall_c;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    // Counter value N means N+1 cycles have been spent in REQ/WAIT.
    assign tmo_c = (state_q != IDLE) && (cnt_q == TMO_LAST);

    always_comb begin
        cnt_d = 8'd0;
        if (state_q != IDLE && state_d != IDLE)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= 8'd0;
        else       cnt_q <= cnt_d;
    end
`else
    assign tmo_c = 1'b0;

    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // Bus FSM: next state, request and stall.
    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_any && !mis_c) begin
                    req_c = 1'b1;
                    if (op_st) begin
                        if (!dmem_gnt) begin
                            stall_c = 1'b1;
                            state_d = REQ;
                        end
                    end else begin
                        stall_c = 1'b1;
                        state_d = dmem_gnt ? WAIT : REQ;
                    end
                end
            end
            REQ: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (dmem_gnt) begin
                    if (op_ld) begin
                        state_d = WAIT;
                    end else begin
                        stall_c = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            WAIT: begin
                stall_c = !dmem_rvalid;
                if (dmem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A timed-out access is dropped and the instruction retires as a bubble.
        if (tmo_c) begin
            state_d = IDLE;
            req_c   = 1'b0;
            stall_c = 1'b0;
        end
    end

    load_align u_load_align (
        .rdata_i  (dmem_rdata),
        .offset_i (offset),
        .func3_i  (mem_func3_in),
        .data_o   (load_val)
    );

    // In WAIT the write-back register updates in the rvalid cycle itself,
    // so the aligned load value is taken straight from the bus.
    always_comb begin
        wb_sel = mem_alu_out_in;
        case (mem_reg_in_sel_in)
            SEL_ALU:   wb_sel = mem_alu_out_in;
            SEL_LOAD:  wb_sel = load_val;
            SEL_PCIMM: wb_sel = mem_pc_imm_in;
            SEL_IMM:   wb_sel = mem_imm_in;
            default:   wb_sel = mem_alu_out_in;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            wb_result_q    <= '0;
            wb_rd_q        <= 5'd0;
            wb_reg_wr_q    <= 1'b0;
            misalign_err_q <= 1'b0;
            err_addr_q     <= '0;
        end else begin
            state_q        <= state_d;
            misalign_err_q <= mis_c || tmo_c;
            if (mis_c || tmo_c)
                err_addr_q <= mem_alu_out_in;
            if (stall_c) begin
                wb_reg_wr_q <= 1'b0;
            end else begin
                wb_rd_q     <= mem_rd_in;
                wb_reg_wr_q <= mem_reg_wr_in && !mis_c && !tmo_c;
                wb_result_q <= wb_sel;
            end
        end
    end

    assign wb_result    = wb_result_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_wr    = wb_reg_wr_q;
    assign misalign_err = misalign_err_q;
    assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed self-checking bench for mem_stage_lsu.
// Inputs change 1ns after the rising edge; combinational outputs are
// checked 1ns later and registered outputs 1ns after the next edge.
// With MEM_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=4.
module tb_mem_stage_lsu;
    import lsu_pkg::*;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk, reset;
    logic [31:0] alu, rv1, pcimm, imm;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [3:0]  dwe;
    logic [2:0]  f3;
    logic        memreg, regwr;
    logic        req, we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic [31:0] wb_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_wr, mis_err;
    logic [31:0] err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .mem_alu_out_in(alu), .mem_rv1_in(rv1), .mem_pc_imm_in(pcimm),
        .mem_imm_in(imm), .mem_rd_in(rd), .mem_reg_in_sel_in(sel),
        .mem_dwe_in(dwe), .mem_func3_in(f3), .mem_mem_reg_in(memreg),
        .mem_reg_wr_in(regwr),
        .dmem_req(req), .dmem_we(we), .dmem_addr(addr), .dmem_be(be),
        .dmem_wdata(wdata), .dmem_gnt(gnt), .dmem_rvalid(rvalid),
        .dmem_rdata(rdata),
        .lsu_stall(stall), .wb_result(wb_result), .wb_rd(wb_rd),
        .wb_reg_wr(wb_reg_wr), .misalign_err(mis_err), .err_addr(err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        alu = 32'd0; rv1 = 32'd0; pcimm = 32'd0; imm = 32'd0;
        rd = 5'd0; sel = SEL_ALU; dwe = 4'd0; f3 = 3'd0;
        memreg = 1'b0; regwr = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    endtask

    task automatic set_load(input logic [31:0] a, input logic [2:0] fn,
                            input logic [4:0] r);
        nop();
        alu = a; f3 = fn; rd = r; memreg = 1'b1; regwr = 1'b1; sel = SEL_LOAD;
    endtask

    task automatic test_reset();
        nop();
        reset = 1'b1;
        memreg = 1'b1; f3 = LW; alu = 32'h100;
        repeat (2) @(posedge clk);
        #2;
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", req); end
        n_checks++; if (wb_result !== 32'd0) begin n_fail++; $display("FAIL reset_wb_result: got %h want 0", wb_result); end
        n_checks++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_wb_rd: got %0d want 0", wb_rd); end
        n_checks++; if (wb_reg_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wb_reg_wr: got %b want 0", wb_reg_wr); end
        n_checks++; if (mis_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", mis_err); end
        n_checks++; if (err_addr !== 32'd0) begin n_fail++; $display("FAIL reset_err_addr: got %h want 0", err_addr); end
        nop();
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_alu_wb();
        nop(); sel = SEL_ALU; alu = 32'h1234_5678; rd = 5'd5; regwr = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL alu_no_bus: stall=%b req=%b want 0/0", stall, req); end
        tick();
        n_checks++; if (wb_result !== 32'h1234_5678 || wb_rd !== 5'd5 || wb_reg_wr !== 1'b1) begin n_fail++; $display("FAIL alu_wb: got %h/%0d/%b want 12345678/5/1", wb_result, wb_rd, wb_reg_wr); end
        sel = SEL_PCIMM; pcimm = 32'hAAAA_0004; rd = 5'd6;
        tick();
        n_checks++; if (wb_result !== 32'hAAAA_0004 || wb_rd !== 5'd6) begin n_fail++; $display("FAIL pcimm_wb: got %h/%0d want aaaa0004/6", wb_result, wb_rd); end
        sel = SEL_IMM; imm = 32'hFFFF_F000; rd = 5'd31; regwr = 1'b0;
        tick();
        n_checks++; if (wb_result !== 32'hFFFF_F000 || wb_rd !== 5'd31 || wb_reg_wr !== 1'b0) begin n_fail++; $display("FAIL imm_wb: got %h/%0d/%b want fffff000/31/0", wb_result, wb_rd, wb_reg_wr); end
        nop();
    endtask

    task automatic test_store();
        nop(); alu = 32'h1003; rv1 = 32'h0000_00AB; dwe = 4'b0001; f3 = SB; gnt = 1'b1;
        #1;
        n_checks++; if (req !== 1'b1 || we !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL sb_ctl: req=%b we=%b stall=%b want 1/1/0", req, we, stall); end
        n_checks++; if (addr !== 32'h1000 || be !== 4'b1000 || wdata !== 32'hAB00_0000) begin n_fail++; $display("FAIL sb_bus: addr=%h be=%b wdata=%h want 1000/1000/ab000000", addr, be, wdata); end
        tick();
        alu = 32'h1002; rv1 = 32'h0000_1234; dwe = 4'b0011; f3 = SH; gnt = 1'b1;
        #1;
        n_checks++; if (be !== 4'b1100 || wdata !== 32'h1234_0000 || stall !== 1'b0) begin n_fail++; $display("FAIL sh_bus: be=%b wdata=%h stall=%b want 1100/12340000/0", be, wdata, stall); end
        tick();
        alu = 32'h1004; rv1 = 32'hCAFE_BABE; dwe = 4'b1111; f3 = SW; gnt = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b1 || req !== 1'b1 || be !== 4'b1111) begin n_fail++; $display("FAIL sw_nognt: stall=%b req=%b be=%b want 1/1/1111", stall, req, be); end
        tick();
        gnt = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0 || req !== 1'b1 || we !== 1'b1 || wdata !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL sw_req_gnt: stall=%b req=%b we=%b wdata=%h want 0/1/1/cafebabe", stall, req, we, wdata); end
        tick();
        nop();
        #1;
        n_checks++; if (req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL sw_done_idle: req=%b stall=%b want 0/0", req, stall); end
        tick();
    endtask

    task automatic test_load_byte(input logic [2:0] fn, input logic [31:0] exp);
        set_load(32'h1002, fn, 5'd7); gnt = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b1 || req !== 1'b1 || we !== 1'b0 || addr !== 32'h1000) begin n_fail++; $display("FAIL lb_issue f3=%0d: stall=%b req=%b we=%b addr=%h want 1/1/0/1000", fn, stall, req, we, addr); end
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h80FF_7F00;
        #1;
        n_checks++; if (stall !== 1'b0 || req !== 1'b0 || wb_reg_wr !== 1'b0) begin n_fail++; $display("FAIL lb_wait f3=%0d: stall=%b req=%b wb_reg_wr=%b want 0/0/0", fn, stall, req, wb_reg_wr); end
        tick();
        n_checks++; if (wb_result !== exp || wb_reg_wr !== 1'b1 || wb_rd !== 5'd7) begin n_fail++; $display("FAIL lb_result f3=%0d: got %h/%b/%0d want %h/1/7", fn, wb_result, wb_reg_wr, wb_rd, exp); end
        nop();
    endtask

    task automatic test_lw_delayed();
        logic exp_stall, exp_req;
        set_load(32'h2000, LW, 5'd9);
        for (int c = 0; c < 6; c++) begin
            gnt    = (c == 3);
            rvalid = (c == 1) || (c == 5);  // cycle-1 pulse is stray (REQ)
            rdata  = (c == 5) ? 32'hDEAD_BEEF : 32'h0BAD_F00D;
            exp_stall = (c < 5);
            exp_req   = (c < 4);
            #1;
            n_checks++; if (stall !== exp_stall || req !== exp_req) begin n_fail++; $display("FAIL lw_delay c=%0d: stall=%b req=%b want %b/%b", c, stall, req, exp_stall, exp_req); end
            if (c < 4) begin
                n_checks++; if (addr !== 32'h2000) begin n_fail++; $display("FAIL lw_delay_addr c=%0d: got %h want 2000", c, addr); end
            end
            if (c > 0) begin
                n_checks++; if (wb_reg_wr !== 1'b0) begin n_fail++; $display("FAIL lw_delay_bubble c=%0d: wb_reg_wr=%b want 0", c, wb_reg_wr); end
            end
            tick();
        end
        n_checks++; if (wb_result !== 32'hDEAD_BEEF || wb_reg_wr !== 1'b1 || wb_rd !== 5'd9) begin n_fail++; $display("FAIL lw_delay_result: got %h/%b/%0d want deadbeef/1/9", wb_result, wb_reg_wr, wb_rd); end
        nop();
    endtask

    task automatic test_misalign();
        set_load(32'h1002, LW, 5'd4);
        #1;
        n_checks++; if (req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL mis_lw_bus: req=%b stall=%b want 0/0", req, stall); end
        tick();
        n_checks++; if (mis_err !== 1'b1 || err_addr !== 32'h1002 || wb_reg_wr !== 1'b0) begin n_fail++; $display("FAIL mis_lw_err: err=%b addr=%h wr=%b want 1/1002/0", mis_err, err_addr, wb_reg_wr); end
        set_load(32'h1006, LH, 5'd8); gnt = 1'b1;
        #1;
        n_checks++; if (req !== 1'b1 || stall !== 1'b1) begin n_fail++; $display("FAIL lh_aligned_issue: req=%b stall=%b want 1/1", req, stall); end
        tick();
        n_checks++; if (mis_err !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_len: err=%b want 0", mis_err); end
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h8001_0000;
        tick();
        n_checks++; if (wb_result !== 32'hFFFF_8001 || wb_reg_wr !== 1'b1) begin n_fail++; $display("FAIL lh_result: got %h/%b want ffff8001/1", wb_result, wb_reg_wr); end
        nop(); alu = 32'h1003; dwe = 4'b0011; f3 = SH; rv1 = 32'h5555; gnt = 1'b1;
        #1;
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL mis_sh_req: req=%b want 0", req); end
        tick();
        n_checks++; if (mis_err !== 1'b1 || err_addr !== 32'h1003) begin n_fail++; $display("FAIL mis_sh_err: err=%b addr=%h want 1/1003", mis_err, err_addr); end
        nop();
        tick();
    endtask

    task automatic test_reset_in_wait();
        set_load(32'h3000, LW, 5'd2); gnt = 1'b1;
        tick();
        gnt = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (req !== 1'b0 || wb_result !== 32'd0 || wb_rd !== 5'd0 || wb_reg_wr !== 1'b0 || mis_err !== 1'b0 || err_addr !== 32'd0) begin n_fail++; $display("FAIL rst_wait_outputs: req=%b res=%h rd=%0d wr=%b err=%b addr=%h want all 0", req, wb_result, wb_rd, wb_reg_wr, mis_err, err_addr); end
        set_load(32'h3004, LW, 5'd2); rvalid = 1'b1; rdata = 32'h1111_1111;
        #1 reset = 1'b0;
        #1;
        n_checks++; if (req !== 1'b1 || stall !== 1'b1) begin n_fail++; $display("FAIL rst_idle_rvalid: req=%b stall=%b want 1/1", req, stall); end
        tick();
        gnt = 1'b1; rdata = 32'h2222_2222;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_req_rvalid: stall=%b want 1", stall); end
        tick();
        gnt = 1'b0; rdata = 32'h3333_3333;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_wait_done: stall=%b want 0", stall); end
        tick();
        n_checks++; if (wb_result !== 32'h3333_3333 || wb_reg_wr !== 1'b1 || wb_rd !== 5'd2) begin n_fail++; $display("FAIL rst_reload_result: got %h/%b/%0d want 33333333/1/2", wb_result, wb_reg_wr, wb_rd); end
        nop();
        tick();
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        set_load(32'h4000, LW, 5'd3);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (stall !== (c < 4)) begin n_fail++; $display("FAIL tmo_stall c=%0d: stall=%b want %b", c, stall, (c < 4)); end
            if (c == 4) begin
                n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL tmo_req: req=%b want 0", req); end
            end
            tick();
        end
        n_checks++; if (mis_err !== 1'b1 || err_addr !== 32'h4000 || wb_reg_wr !== 1'b0) begin n_fail++; $display("FAIL tmo_err: err=%b addr=%h wr=%b want 1/4000/0", mis_err, err_addr, wb_reg_wr); end
        nop();
        tick();
        n_checks++; if (mis_err !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse: err=%b want 0", mis_err); end
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        bad = 0;
        set_load(32'h4000, LW, 5'd3);
        for (int c = 0; c < 300; c++) begin
            #1;
            if (stall !== 1'b1 || req !== 1'b1) bad++;
            tick();
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL no_timeout_hold: %0d cycles dropped stall/req, want 0", bad); end
        gnt = 1'b1;
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0042;
        tick();
        n_checks++; if (wb_result !== 32'h42 || wb_reg_wr !== 1'b1 || mis_err !== 1'b0) begin n_fail++; $display("FAIL no_timeout_result: got %h/%b/%b want 42/1/0", wb_result, wb_reg_wr, mis_err); end
        nop();
        tick();
    endtask
`endif

    initial begin
        reset = 1'b1;
        nop();
        test_reset();
        test_alu_wb();
        test_store();
        test_load_byte(LB,  32'hFFFF_FFFF);
        test_load_byte(LBU, 32'h0000_00FF);
        test_lw_delayed();
        test_misalign();
        test_reset_in_wait();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
